mlp_infer_ctrl: RTL and testbench

//  Sequences one inference of the Clash MLP core from board controls: captures switch vector, pulses core start,

---
 rtl/mlp_ctrl_pkg.sv | 20 ++
 rtl/key_debounce.sv | 53 +++++
 rtl/mlp_infer_ctrl.sv | 137 +++++++++++++
 tb/tb_mlp_infer_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_ctrl_pkg.sv
// Shared types and defaults for the MLP inference controller.
package mlp_ctrl_pkg;

    localparam int SW_W_DEF  = 10;
    localparam int OUT_W_DEF = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        LATCH = 3'd4
    } state_e;

    // States during which a run is in flight towards the core.
    function automatic logic is_busy(input state_e s);
        return (s == START) || (s == WAIT) || (s == LATCH);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and
// a one-cycle pulse on each debounced press (1->0 transition).
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced level disagrees with the
    // debounced level; any bounce back to the old level restarts it.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = deb_q & ~deb_d;
    end

    // Synchronizer and debounce state; released button is the reset level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mlp_infer_ctrl.sv
// Sequences one MLP core inference per trigger: loads the synced switch
// vector, pulses start, waits for done with a timeout, latches the result.
module mlp_infer_ctrl
    import mlp_ctrl_pkg::*;
#(
    parameter int SW_W         = SW_W_DEF,
    parameter int OUT_W        = OUT_W_DEF,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int TIMEOUT_CYC  = 65535
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic             key_n,
    input  logic             auto_en,
    input  logic [SW_W-1:0]  sw_in,
    output logic [SW_W-1:0]  core_x,
    output logic             core_start,
    input  logic             core_done,
    input  logic [OUT_W-1:0] core_y,
    output logic [OUT_W-1:0] led,
    output logic             busy,
    output logic             err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    state_e           state_q, state_d;
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    logic [SW_W-1:0]  core_x_q, core_x_d;
    logic [SW_W-1:0]  last_x_q, last_x_d;
    logic [OUT_W-1:0] led_q, led_d;
    logic             err_q, err_d;
    logic             pending_q, pending_d;
    logic             busy_q;
    logic [TW-1:0]    wcnt_q, wcnt_d;
    logic             press;
    logic             trigger;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key (
        .clk_i   (system1000),
        .rst_ni  (system1000_rstn),
        .key_n_i (key_n),
        .press_o (press)
    );

    assign trigger = press | (auto_en & (sw_s2_q != last_x_q));

    // Next-state logic; triggers arriving mid-run collapse into one pending run.
    always_comb begin
        state_d   = state_q;
        core_x_d  = core_x_q;
        last_x_d  = last_x_q;
        led_d     = led_q;
        err_d     = err_q;
        pending_d = pending_q;
        wcnt_d    = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (trigger || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                // Any trigger seen here is already satisfied by this load.
                core_x_d = sw_s2_q;
                last_x_d = sw_s2_q;
                state_d  = START;
            end
            START: begin
                if (trigger) pending_d = 1'b1;
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (trigger) pending_d = 1'b1;
                if (core_done) begin
                    led_d   = core_y;
                    state_d = LATCH;
                end else if (wcnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            LATCH: begin
                err_d = 1'b0;
                if (pending_q) begin
                    pending_d = 1'b0;
                    state_d   = LOAD;
                end else begin
                    if (trigger) pending_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, synchronizer and output registers.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q   <= IDLE;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            core_x_q  <= '0;
            last_x_q  <= '0;
            led_q     <= '0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            sw_s1_q   <= sw_in;
            sw_s2_q   <= sw_s1_q;
            core_x_q  <= core_x_d;
            last_x_q  <= last_x_d;
            led_q     <= led_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            busy_q    <= is_busy(state_d);
            wcnt_q    <= wcnt_d;
        end
    end

    // Decoded straight from the state register so reset removes it at once.
    assign core_start  = (state_q == START);
    assign core_x      = core_x_q;
    assign led         = led_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Bench for mlp_infer_ctrl: table vectors, multi-cycle corner sequences and
// randomized runs against a per-transaction reference model.
module tb_mlp_infer_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       key_n = 1'b1;
    logic       auto_en = 1'b0;
    logic [9:0] sw_in = '0;
    logic [9:0] core_x;
    logic       core_start;
    logic       core_done = 1'b0;
    logic [9:0] core_y = '0;
    logic [9:0] led;
    logic       busy;
    logic       err_timeout;

    always #5 clk = ~clk;

    mlp_infer_ctrl #(
        .SW_W         (10),
        .OUT_W        (10),
        .DEBOUNCE_CYC (4),
        .TIMEOUT_CYC  (16)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .key_n           (key_n),
        .auto_en         (auto_en),
        .sw_in           (sw_in),
        .core_x          (core_x),
        .core_start      (core_start),
        .core_done       (core_done),
        .core_y          (core_y),
        .led             (led),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    // Core model: answers y = x + 1 five cycles after start unless silenced.
    bit         silent = 1'b0;
    int         cd = 0;
    logic [9:0] cx = '0;
    always @(negedge clk) begin
        core_done <= 1'b0;
        if (core_start) begin
            cd <= 5;
            cx <= core_x;
        end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1 && !silent) begin
                core_done <= 1'b1;
                core_y    <= cx + 10'd1;
            end
        end
    end

    int         errors = 0;
    int         checks = 0;
    int         start_total = 0;
    bit         prev_start = 1'b0;
    logic [9:0] xh0 = '0, xh1 = '0;

    // Reference model state: one entry per completed transaction.
    logic [9:0] m_last = '0, m_led = '0;
    bit         m_err = 1'b0;

    typedef struct {
        logic [9:0] sw;
        bit         press;
        bit         aen;
        bit         sil;
        int         starts;
        logic [9:0] led;
        bit         err;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (core_start === 1'b1) begin
            start_total++;
            xh1 = xh0;
            xh0 = core_x;
            chk("start_single_cycle", 32'(prev_start), 32'd0);
        end
        prev_start = (core_start === 1'b1);
    endtask

    task automatic run_vec(input logic [9:0] sw, input bit press, input bit a,
                           input bit sil, output int starts);
        int s0;
        s0 = start_total;
        auto_en = 1'b0;
        silent  = sil;
        sw_in   = sw;
        repeat (4) tick();
        auto_en = a;
        if (press) begin
            key_n = 1'b0;
            repeat (6) tick();
            key_n = 1'b1;
        end
        repeat (60) tick();
        starts = start_total - s0;
    endtask

    task automatic model_step(input logic [9:0] sw, input bit press, input bit a,
                              input bit sil, output int exp_starts);
        exp_starts = 0;
        if (press || (a && sw != m_last)) begin
            exp_starts = 1;
            m_last = sw;
            if (sil) m_err = 1'b1;
            else begin
                m_led = sw + 10'd1;
                m_err = 1'b0;
            end
        end
    endtask

    task automatic check_idle(input string tag, input int starts, input int exp_starts,
                              input logic [9:0] exp_led, input bit exp_err);
        chk({tag, "_starts"}, 32'(starts), 32'(exp_starts));
        chk({tag, "_led"}, 32'(led), 32'(exp_led));
        chk({tag, "_err"}, 32'(err_timeout), 32'(exp_err));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_core_x"}, 32'(core_x), 32'(m_last));
    endtask

    initial begin
        int starts, exp_s, s0;
        logic [9:0] rsw;
        int mode;
        bit rp, ra, rs;

        repeat (3) tick();
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_core_x", 32'(core_x), 32'd0);
        rstn = 1'b1;
        tick();

        //             sw     press aen sil starts led    err
        tbl[0] = '{10'h3FF, 1'b1, 1'b0, 1'b0, 1, 10'h000, 1'b0};
        tbl[1] = '{10'h155, 1'b1, 1'b0, 1'b0, 1, 10'h156, 1'b0};
        tbl[2] = '{10'h0F0, 1'b1, 1'b0, 1'b1, 1, 10'h156, 1'b1};
        tbl[3] = '{10'h020, 1'b1, 1'b0, 1'b0, 1, 10'h021, 1'b0};
        tbl[4] = '{10'h001, 1'b0, 1'b1, 1'b0, 1, 10'h002, 1'b0};
        tbl[5] = '{10'h002, 1'b0, 1'b1, 1'b0, 1, 10'h003, 1'b0};
        tbl[6] = '{10'h002, 1'b0, 1'b1, 1'b0, 0, 10'h003, 1'b0};
        tbl[7] = '{10'h2AA, 1'b0, 1'b0, 1'b0, 0, 10'h003, 1'b0};
        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i].sw, tbl[i].press, tbl[i].aen, tbl[i].sil, starts);
            model_step(tbl[i].sw, tbl[i].press, tbl[i].aen, tbl[i].sil, exp_s);
            check_idle($sformatf("row%0d", i), starts, tbl[i].starts, tbl[i].led, tbl[i].err);
        end

        // Key chatter never stable long enough: no run.
        s0 = start_total;
        for (int i = 0; i < 20; i++) begin
            key_n = ((i % 4) < 2) ? 1'b0 : 1'b1;
            tick();
        end
        key_n = 1'b1;
        repeat (30) tick();
        check_idle("chatter", start_total - s0, 0, m_led, m_err);

        // Auto launch of 0x100, key press lands while waiting on the core
        // with sw already moved to 0x0AA: the pending run loads 0x0AA.
        silent = 1'b0;
        auto_en = 1'b0;
        sw_in = 10'h100;
        repeat (4) tick();
        s0 = start_total;
        key_n = 1'b0;
        tick();
        auto_en = 1'b1;
        tick();
        auto_en = 1'b0;
        tick();
        sw_in = 10'h0AA;
        repeat (3) tick();
        key_n = 1'b1;
        repeat (40) tick();
        m_last = 10'h0AA;
        m_led = 10'h0AB;
        m_err = 1'b0;
        chk("pend_first_x", 32'(xh1), 32'h100);
        check_idle("pend", start_total - s0, 2, 10'h0AB, 1'b0);

        // Reset asserted while waiting on the core.
        sw_in = 10'h0C3;
        repeat (4) tick();
        s0 = start_total;
        key_n = 1'b0;
        repeat (6) tick();
        key_n = 1'b1;
        for (int i = 0; i < 40 && start_total == s0; i++) tick();
        chk("rstmid_start_seen", 32'(start_total - s0), 32'd1);
        repeat (2) tick();
        chk("rstmid_busy_before", 32'(busy), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rstmid_core_start", 32'(core_start), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_led", 32'(led), 32'd0);
        chk("rstmid_err", 32'(err_timeout), 32'd0);
        tick();
        rstn = 1'b1;
        m_last = '0;
        m_led = '0;
        m_err = 1'b0;
        s0 = start_total;
        repeat (20) tick();
        check_idle("late_done", start_total - s0, 0, 10'h000, 1'b0);
        run_vec(10'h0C3, 1'b1, 1'b0, 1'b0, starts);
        model_step(10'h0C3, 1'b1, 1'b0, 1'b0, exp_s);
        check_idle("after_rst", starts, exp_s, m_led, m_err);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 24; i++) begin
            mode = int'($urandom_range(0, 3));
            rsw  = 10'($urandom_range(0, 1023));
            if (mode == 2) rsw = m_last;
            rp = (mode == 0);
            ra = (mode == 1) || (mode == 2);
            rs = ($urandom_range(0, 5) == 0);
            run_vec(rsw, rp, ra, rs, starts);
            model_step(rsw, rp, ra, rs, exp_s);
            check_idle($sformatf("rnd%0d", i), starts, exp_s, m_led, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
